mem_bist_ctrl: RTL and testbench
================================

# mem_bist_ctrl

Built-in self-test controller that drives the write and read ports of a `dual_port_memory` instance. It runs a March C- sequence over every word and compares read data against expected backgrounds. It reports pass/fail plus the first failing address and data. It sits beside each RAM instance and owns both RAM ports while `busy` is high. A system-level mux, outside this block, returns the ports to functional traffic otherwise.

## Interface
- `DATA_WIDTH`, 32: RAM word width.
- `ADDR_WIDTH`, 8: RAM address width. Depth N = 2**ADDR_WIDTH.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: one-cycle request to begin a test. Sampled only in IDLE.
- `busy`  out  1: test in progress.
- `done`  out  1: one-cycle pulse at test completion.
- `pass`  out  1: valid from `done` until the next accepted `start`. 1 = no mismatch.
- `fail_addr`  out  ADDR_WIDTH: address of the first mismatch.
- `fail_data`  out  DATA_WIDTH: read data actually returned at the first mismatch.
- `mem_wr_en`  out  1: to RAM write enable.
- `mem_wr_addr`  out  ADDR_WIDTH: to RAM write address.
- `mem_wr_data`  out  DATA_WIDTH: to RAM write data.
- `mem_rd_en`  out  1: to RAM read enable.
- `mem_rd_addr`  out  ADDR_WIDTH: to RAM read address.
- `mem_rd_data`  in  DATA_WIDTH: from RAM. Registered, valid one cycle after `mem_rd_en`.

## Operation
- Backgrounds: B0 = all zeros, B1 = all ones.
- March C- elements, in order:
  - E0 ascending: w B0.
  - E1 ascending: r B0, w B1.
  - E2 ascending: r B1, w B0.
  - E3 descending: r B0, w B1.
  - E4 descending: r B1, w B0.
  - E5 ascending: r B0.
- Ascending runs address 0 to N-1. Descending runs N-1 to 0.
- Every address counter step is an unsigned ADDR_WIDTH-bit increment or decrement. Terminal detection is done on the value before the step, so the wrap is never observed.
- One RAM operation per cycle; read and write are never issued in the same cycle.
- In E1–E4, each address takes 2 cycles: the read cycle, then the write cycle to the same address.
- States:
  - IDLE: on `start`, go to W0.
  - W0: E0. Go to RD after address N-1.
  - RD: read cycle of E1–E4; always go to WR.
  - WR: go to RD at the next address. At the end of an element, go to RD at the next element's start address. After E4, go to R5.
  - R5: E5. Go to DRAIN after address N-1.
  - DRAIN: wait for the final compare; always go to IDLE.
- Compare pipeline: each read registers the expected value, the address and a valid bit alongside `mem_rd_en`. One cycle later, `mem_rd_data` is compared against the expected value.
- On the first mismatch, `fail_addr`/`fail_data` are latched and a sticky error flag is set. Later mismatches do not update them.
- The test always runs to completion; there is no early abort.
- `pass` = NOT error flag, driven when `done` fires.
- `start` while busy is ignored.
- An accepted `start` clears the error flag, `pass`, `fail_addr` and `fail_data`.

## Timing
- Reset values: `busy`, `done`, `pass` = 0; `fail_addr`, `fail_data` = 0; all `mem_*` outputs = 0; state IDLE.
- Reset mid-test aborts immediately. RAM contents are then undefined. The next `start` runs a full test.
- Let `start` be sampled at edge E(0). Op k (k = 1..10N) is driven during the cycle after E(k-1).
- `busy` is high from E(0) through E(10N+1).
- `done` is high for the single cycle after E(10N+1), simultaneous with `busy` falling.
- Total: 10N+1 cycles busy. For ADDR_WIDTH=8 that is 2561; for ADDR_WIDTH=4 it is 161.
- `mem_wr_en`/`mem_rd_en` are high only in their own op cycle. Address and data outputs hold their last value when the enables are low.

## Structure
- Package `mem_bist_pkg` holds:
  - the state enum;
  - `NUM_ELEMENTS` = 6;
  - a constant march table indexed by element: direction, has_read, read background, has_write, write background.
- FSM and sequencing stay in `mem_bist_ctrl`.
- One sub-module is natural: `mem_bist_cmp`, the one-stage compare pipeline with the sticky first-fail capture.

## Test plan
- ADDR_WIDTH=4, fault-free `dual_port_memory`, `start` pulse → `done` after edge 161, `pass`=1, `fail_addr`=0, `fail_data`=0.
- Port trace check, same setup → op 17 is a read of 0x0 and op 18 a write of 0x0 with all ones. The first E3 read (op 81) is at address 0xF.
- Stuck-at-1 injected on bit 5 of word 0x3C (ADDR_WIDTH=8) → `pass`=0, `fail_addr`=0x3C, `fail_data`=0x00000020. The first E1 failure is kept and later mismatches do not overwrite it.
- `start` pulsed again at cycle 50 of a running test → ignored. `done` still arrives at edge 161, exactly once.
- `rst` asserted at cycle 100 → all outputs 0 within the same cycle. A new `start` then completes with `pass`=1 after 161 edges.
- Back-to-back: fail run, then a fault-free run → the second `start` clears `fail_addr`/`fail_data`/`pass`, and the second `done` reports `pass`=1.

Source files
------------

// File: rtl/mem_bist_pkg.sv
`default_nettype none
// ============================================================================
// mem_bist_pkg : shared types and the March C- element table for mem_bist_ctrl
// Rev 1.0
// ============================================================================
package mem_bist_pkg;

  localparam int NUM_ELEMENTS = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_W0    = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_R5    = 3'd4,
    ST_DRAIN = 3'd5
  } bist_state_e;

  typedef struct packed {
    logic desc;    // 1 = descending address order
    logic has_rd;
    logic rd_bg;   // 0 = all zeros, 1 = all ones
    logic has_wr;
    logic wr_bg;
  } march_elem_t;

  // Entry 0 is E0; the packed array is listed highest index first.
  localparam march_elem_t [NUM_ELEMENTS-1:0] c_march_table = {
    march_elem_t'{desc: 1'b0, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b0, wr_bg: 1'b0},
    march_elem_t'{desc: 1'b1, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0},
    march_elem_t'{desc: 1'b1, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1},
    march_elem_t'{desc: 1'b0, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0},
    march_elem_t'{desc: 1'b0, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1},
    march_elem_t'{desc: 1'b0, has_rd: 1'b0, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b0}
  };

endpackage
`default_nettype wire

// File: rtl/mem_bist_cmp.sv
`default_nettype none
// ============================================================================
// mem_bist_cmp : one-stage read compare with sticky first-failure capture
// Rev 1.0
// ============================================================================
module mem_bist_cmp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_exp,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_err_next,
  output logic [ADDR_WIDTH-1:0] o_fail_addr,
  output logic [DATA_WIDTH-1:0] o_fail_data
);

  logic                  r_vld;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_exp;
  logic                  r_err;
  logic                  w_mis;

  assign w_mis      = r_vld && (i_rd_data != r_exp);
  // Includes the compare in flight so the final read is reflected in pass.
  assign o_err_next = r_err | w_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld       <= 1'b0;
      r_addr      <= '0;
      r_exp       <= '0;
      r_err       <= 1'b0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
    end else begin
      r_vld  <= i_rd_en;
      r_addr <= i_rd_addr;
      r_exp  <= i_rd_exp;
      if (i_clr) begin
        r_err       <= 1'b0;
        o_fail_addr <= '0;
        o_fail_data <= '0;
      end else if (w_mis && !r_err) begin
        r_err       <= 1'b1;
        o_fail_addr <= r_addr;
        o_fail_data <= i_rd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bist_ctrl.sv
`default_nettype none
// ============================================================================
// mem_bist_ctrl : March C- BIST sequencer driving both ports of a RAM
// Rev 1.0
// ============================================================================
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [ADDR_WIDTH-1:0] o_fail_addr,
  output logic [DATA_WIDTH-1:0] o_fail_data,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data
);

  localparam logic [ADDR_WIDTH-1:0] C_ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = 1;

  bist_state_e           r_state;
  logic [2:0]            r_elem;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_rd_exp;

  logic                  w_start_acc;
  logic                  w_err_next;
  logic [2:0]            w_elem_nxt;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_nxt_start;
  logic [ADDR_WIDTH-1:0] w_nx_addr;
  logic                  w_nx_rbg;

  assign w_start_acc = (r_state == ST_IDLE) && i_start;
  assign w_elem_nxt  = r_elem + 3'd1;

  // Terminal test uses the pre-step address so the counter wrap is never seen.
  assign w_last      = c_march_table[r_elem].desc ? (r_addr == '0) : (r_addr == C_ADDR_MAX);
  assign w_step      = c_march_table[r_elem].desc ? (r_addr - C_ADDR_ONE) : (r_addr + C_ADDR_ONE);
  assign w_nxt_start = c_march_table[w_elem_nxt].desc ? C_ADDR_MAX : '0;
  assign w_nx_addr   = w_last ? w_nxt_start : w_step;
  assign w_nx_rbg    = w_last ? c_march_table[w_elem_nxt].rd_bg : c_march_table[r_elem].rd_bg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_elem        <= '0;
      r_addr        <= '0;
      r_rd_exp      <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_pass        <= 1'b0;
      o_mem_wr_en   <= 1'b0;
      o_mem_wr_addr <= '0;
      o_mem_wr_data <= '0;
      o_mem_rd_en   <= 1'b0;
      o_mem_rd_addr <= '0;
    end else begin
      o_done      <= 1'b0;
      o_mem_wr_en <= 1'b0;
      o_mem_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state       <= ST_W0;
            r_elem        <= '0;
            r_addr        <= '0;
            o_busy        <= 1'b1;
            o_pass        <= 1'b0;
            o_mem_wr_en   <= 1'b1;
            o_mem_wr_addr <= '0;
            o_mem_wr_data <= {DATA_WIDTH{c_march_table[0].wr_bg}};
          end
        end
        ST_W0: begin
          if (w_last) begin
            r_state       <= ST_RD;
            r_elem        <= w_elem_nxt;
            r_addr        <= w_nx_addr;
            o_mem_rd_en   <= 1'b1;
            o_mem_rd_addr <= w_nx_addr;
            r_rd_exp      <= {DATA_WIDTH{w_nx_rbg}};
          end else begin
            r_addr        <= w_step;
            o_mem_wr_en   <= 1'b1;
            o_mem_wr_addr <= w_step;
            o_mem_wr_data <= {DATA_WIDTH{c_march_table[r_elem].wr_bg}};
          end
        end
        ST_RD: begin
          r_state       <= ST_WR;
          o_mem_wr_en   <= 1'b1;
          o_mem_wr_addr <= r_addr;
          o_mem_wr_data <= {DATA_WIDTH{c_march_table[r_elem].wr_bg}};
        end
        ST_WR: begin
          if (w_last) begin
            r_elem  <= w_elem_nxt;
            r_state <= c_march_table[w_elem_nxt].has_wr ? ST_RD : ST_R5;
          end else begin
            r_state <= ST_RD;
          end
          r_addr        <= w_nx_addr;
          o_mem_rd_en   <= 1'b1;
          o_mem_rd_addr <= w_nx_addr;
          r_rd_exp      <= {DATA_WIDTH{w_nx_rbg}};
        end
        ST_R5: begin
          if (w_last) begin
            r_state <= ST_DRAIN;
          end else begin
            r_addr        <= w_step;
            o_mem_rd_en   <= 1'b1;
            o_mem_rd_addr <= w_step;
            r_rd_exp      <= {DATA_WIDTH{w_nx_rbg}};
          end
        end
        ST_DRAIN: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
          o_done  <= 1'b1;
          o_pass  <= ~w_err_next;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mem_bist_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cmp (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_start_acc),
    .i_rd_en     (o_mem_rd_en),
    .i_rd_addr   (o_mem_rd_addr),
    .i_rd_exp    (r_rd_exp),
    .i_rd_data   (i_mem_rd_data),
    .o_err_next  (w_err_next),
    .o_fail_addr (o_fail_addr),
    .o_fail_data (o_fail_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_bist_ctrl : randomized bench with a RAM + stuck-at model and a
//                    March C- reference built from the element list.
// Rev 1.0
// ============================================================================
module tb_mem_bist_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          o_busy, o_done, o_pass;
  logic [AW-1:0] o_fail_addr;
  logic [DW-1:0] o_fail_data;
  logic          o_mem_wr_en, o_mem_rd_en;
  logic [AW-1:0] o_mem_wr_addr, o_mem_rd_addr;
  logic [DW-1:0] o_mem_wr_data;
  logic [DW-1:0] i_mem_rd_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_pass        (o_pass),
    .o_fail_addr   (o_fail_addr),
    .o_fail_data   (o_fail_data),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_wr_addr (o_mem_wr_addr),
    .o_mem_wr_data (o_mem_wr_data),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_rd_addr (o_mem_rd_addr),
    .i_mem_rd_data (i_mem_rd_data)
  );

  // RAM with one optional stuck-at cell bit
  logic [DW-1:0] ram [N];
  bit            f_en;
  int            f_addr, f_bit;
  bit            f_val;

  function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (o_mem_wr_en) ram[o_mem_wr_addr] <= o_mem_wr_data;
    if (o_mem_rd_en) i_mem_rd_data <= faulty(int'(o_mem_rd_addr), ram[o_mem_rd_addr]);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // March C- described as a list of elements
  typedef struct {
    bit wr;
    int addr;
    logic [DW-1:0] data;
  } op_t;

  bit e_desc [6] = '{0, 0, 0, 1, 1, 0};
  bit e_hrd  [6] = '{0, 1, 1, 1, 1, 1};
  bit e_rbg  [6] = '{0, 0, 1, 0, 1, 0};
  bit e_hwr  [6] = '{1, 1, 1, 1, 1, 0};
  bit e_wbg  [6] = '{0, 1, 0, 1, 0, 0};

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, 64'({o_busy, o_done, o_pass, o_mem_wr_en, o_mem_rd_en,
                              o_fail_addr, o_mem_wr_addr, o_mem_rd_addr}), 64'd0);
    check({tag, "_fd"}, 64'(o_fail_data), 64'd0);
    check({tag, "_wd"}, 64'(o_mem_wr_data), 64'd0);
  endtask

  task automatic run_test(input bit fault, input int restart_at, input int rst_at);
    op_t           ops[$];
    op_t           op;
    logic [DW-1:0] mm [N];
    logic [DW-1:0] v;
    bit            exp_pass;
    int            exp_fa;
    logic [DW-1:0] exp_fd;

    f_en   = fault;
    f_addr = $urandom_range(0, N - 1);
    f_bit  = $urandom_range(0, DW - 1);
    f_val  = 1'($urandom_range(0, 1));

    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        a = e_desc[e] ? (N - 1 - i) : i;
        if (e_hrd[e]) ops.push_back('{wr: 1'b0, addr: a, data: {DW{e_rbg[e]}}});
        if (e_hwr[e]) ops.push_back('{wr: 1'b1, addr: a, data: {DW{e_wbg[e]}}});
      end
    end

    exp_pass = 1'b1;
    exp_fa   = 0;
    exp_fd   = '0;
    foreach (ops[i]) begin
      if (ops[i].wr) mm[ops[i].addr] = ops[i].data;
      else begin
        v = faulty(ops[i].addr, mm[ops[i].addr]);
        if (v !== ops[i].data && exp_pass) begin
          exp_pass = 1'b0;
          exp_fa   = ops[i].addr;
          exp_fd   = v;
        end
      end
    end

    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10 * N; k++) begin
      @(negedge clk);
      i_start = (k == restart_at);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check_quiet("midrst");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (k == 1) begin
        check("clr_pass", 64'(o_pass), 64'd0);
        check("clr_fa", 64'(o_fail_addr), 64'd0);
        check("clr_fd", 64'(o_fail_data), 64'd0);
      end
      op = ops[k-1];
      check("busy_done", 64'({o_busy, o_done}), 64'(2'b10));
      check("op_en", 64'({o_mem_wr_en, o_mem_rd_en}), op.wr ? 64'(2'b10) : 64'(2'b01));
      if (op.wr) begin
        check("wr_addr", 64'(o_mem_wr_addr), 64'(op.addr));
        check("wr_data", 64'(o_mem_wr_data), 64'(op.data));
      end else begin
        check("rd_addr", 64'(o_mem_rd_addr), 64'(op.addr));
      end
    end
    @(negedge clk);
    i_start = 1'b0;
    check("drain", 64'({o_busy, o_done, o_mem_wr_en, o_mem_rd_en}), 64'(4'b1000));
    @(negedge clk);
    check("done", 64'({o_busy, o_done}), 64'(2'b01));
    check("pass", 64'(o_pass), 64'(exp_pass));
    check("fail_addr", 64'(o_fail_addr), 64'(exp_fa));
    check("fail_data", 64'(o_fail_data), 64'(exp_fd));
    @(negedge clk);
    check("after", 64'({o_busy, o_done, o_pass}), 64'({2'b00, exp_pass}));
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    i_start = 1'b0;
    for (int i = 0; i < N; i++) ram[i] = $urandom;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    run_test(1'b0, 0, 0);
    for (int t = 0; t < 4; t++) run_test(1'b1, 0, 0);
    run_test(1'b0, 0, 0);
    run_test(1'b0, 50, 0);
    run_test(1'b0, $urandom_range(2, 10 * N), 0);
    run_test(1'b1, 0, 100);
    run_test(1'b0, 0, 0);
    run_test(1'b1, 0, $urandom_range(1, 10 * N));
    run_test(1'b1, 0, 0);
    run_test(1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
